servant_pwr_ctrl: RTL and testbench
===================================

SERVANT_PWR_CTRL -- requirements
Module: servant_pwr_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the ext_irq synchronizer (minimum 2).
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 16, meaning clock-enabled cycles granted after a sleep request before gating (1..255).
REQ-003 The block SHALL have parameter WAKE_CYCLES, default 8, meaning gated settle cycles between a wake event and re-enabling the clock (1..255).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single free-running clock; all state is on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port i_sleep_req, input, 1 bit: single-cycle sleep request pulse from the core.
REQ-007 The block SHALL have port i_wakeup_req, input, 1 bit: single-cycle wakeup request pulse.
REQ-008 The block SHALL have port i_ext_irq, input, 1 bit: asynchronous external interrupt level.
REQ-009 The block SHALL have port i_irq_ack, input, 1 bit: single-cycle clear of the pending interrupt.
REQ-010 The block SHALL have port o_clk_en, output, 1 bit: gate enable for the core clock, driven by a register.
REQ-011 The block SHALL have port o_irq_pending, output, 1 bit: sticky synchronized interrupt flag.
REQ-012 The block SHALL have port o_state, output, 2 bits: current FSM state encoding.

Function
REQ-013 The FSM SHALL have four states, with encoding RUN=0, DRAIN=1, SLEEP=2, WAKE=3.
REQ-014 A wake event SHALL be i_wakeup_req, or a rising edge of synchronized i_ext_irq (0->1 between consecutive synchronizer outputs).
REQ-015 In RUN, i_sleep_req without a same-cycle wake event SHALL enter DRAIN, load the counter with DRAIN_CYCLES-1 and keep o_clk_en=1; if a wake event occurs in the same cycle, the FSM SHALL stay in RUN.
REQ-016 In DRAIN, the counter SHALL decrement each cycle; a wake event SHALL return the FSM to RUN immediately; at counter 0 without a wake event, the FSM SHALL enter SLEEP and o_clk_en SHALL be 0 from the next cycle.
REQ-017 In DRAIN, i_sleep_req SHALL be ignored and SHALL NOT restart the counter.
REQ-018 In SLEEP, o_clk_en SHALL be 0, i_sleep_req SHALL be ignored, and a wake event SHALL enter WAKE and load the counter with WAKE_CYCLES-1.
REQ-019 In WAKE, o_clk_en SHALL remain 0, the counter SHALL decrement, further wake and sleep events SHALL be ignored, and at counter 0 the FSM SHALL enter RUN with o_clk_en=1 on the next cycle.
REQ-020 o_irq_pending SHALL set on a synchronized rising edge and clear on i_irq_ack; if both occur in the same cycle, set SHALL win.
REQ-021 o_irq_pending SHALL update in every state, regardless of o_clk_en.
REQ-022 The counter SHALL be 8 bits wide, unsigned, and SHALL never wrap, because it is only decremented while non-zero.
REQ-023 Latency from i_ext_irq rising to the wake event SHALL be SYNC_STAGES+1 cycles.

Reset
REQ-024 While i_rst_n=0, the block SHALL asynchronously force: state=RUN, o_clk_en=1, counter=0, o_irq_pending=0, synchronizer and edge flops=0.
REQ-025 Reset asserted mid-DRAIN, mid-SLEEP or mid-WAKE SHALL abort the operation, with no residual pending state.
REQ-026 Reset deassertion SHALL take effect on the next i_clk rising edge; the first edge after release SHALL NOT generate a spurious irq edge.

Configuration
REQ-027 Macro SERVANT_PWR_CTRL_IRQ_WAKE_EN SHALL compile external-interrupt wake in or out.
REQ-028 When SERVANT_PWR_CTRL_IRQ_WAKE_EN is defined, REQ-014 and REQ-020 SHALL apply in full.
REQ-029 When SERVANT_PWR_CTRL_IRQ_WAKE_EN is undefined, the synchronizer SHALL be removed, i_ext_irq and i_irq_ack SHALL be ignored, o_irq_pending SHALL be tied to 0, and only i_wakeup_req SHALL wake the block.

Structure
REQ-030 Package servant_pwr_pkg SHALL hold the state typedef/encoding, counter width constant (8) and parameter-range limits.
REQ-031 Sub-module servant_sync SHALL implement the SYNC_STAGES-deep reset-to-0 synchronizer and SHALL be instantiated only under the macro.

Verification
REQ-032 Reset, then i_sleep_req pulse with DRAIN_CYCLES=16 -> o_clk_en=1 for 16 cycles, then 0; o_state=2.
REQ-033 In SLEEP, i_wakeup_req -> o_state=3 for 8 cycles with o_clk_en=0, then o_state=0 and o_clk_en=1.
REQ-034 i_sleep_req and i_wakeup_req in the same cycle in RUN -> stays RUN; i_wakeup_req at DRAIN count 5 -> RUN next cycle, o_clk_en never drops.
REQ-035 (macro defined) In SLEEP, i_ext_irq 0->1 -> o_irq_pending=1 and WAKE entered 3 cycles later; i_irq_ack coincident with a new edge -> o_irq_pending stays 1.
REQ-036 i_rst_n pulled low at WAKE count 4 -> o_clk_en=1, o_state=0, o_irq_pending=0 immediately, without waiting for a clock.
REQ-037 (macro undefined) i_ext_irq toggling in SLEEP -> remains SLEEP and o_irq_pending=0.

Source files
------------

// File: rtl/servant_pwr_pkg.sv
// Shared types and limits for the servant power controller.
// Optional build macro: SERVANT_PWR_CTRL_IRQ_WAKE_EN (external-interrupt wake).
package servant_pwr_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } pwr_state_e;

    localparam int CNT_W           = 8;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_CYCLES      = 1;
    localparam int MAX_CYCLES      = 255;

    // Counter preload for a phase lasting n cycles, saturated to the legal range.
    function automatic logic [CNT_W-1:0] cycles_to_load(input int n);
        if (n <= MIN_CYCLES) begin
            return '0;
        end else if (n >= MAX_CYCLES) begin
            return CNT_W'(MAX_CYCLES - 1);
        end else begin
            return CNT_W'(n - 1);
        end
    endfunction

    function automatic int clamp_sync_stages(input int n);
        return (n < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : n;
    endfunction

endpackage

// File: rtl/servant_pwr_ctrl_if.sv
// Request/status bundle between the core and the power controller.
// The master side issues requests; the slave side is the controller.
interface servant_pwr_ctrl_if;
    logic       sleep_req;
    logic       wakeup_req;
    logic       ext_irq;
    logic       irq_ack;
    logic       clk_en;
    logic       irq_pending;
    logic [1:0] state;

    modport master (
        output sleep_req, wakeup_req, ext_irq, irq_ack,
        input  clk_en, irq_pending, state
    );

    modport slave (
        input  sleep_req, wakeup_req, ext_irq, irq_ack,
        output clk_en, irq_pending, state
    );
endinterface

// File: rtl/servant_pwr_ctrl_fsm.sv
// Sleep/wake sequencing FSM with drain and settle counters plus irq flag.
// SERVANT_PWR_CTRL_IRQ_WAKE_EN compiles in the external-interrupt wake path.
module servant_pwr_ctrl_fsm
    import servant_pwr_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DRAIN_CYCLES = 16,
    parameter int WAKE_CYCLES  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    servant_pwr_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = cycles_to_load(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LOAD  = cycles_to_load(WAKE_CYCLES);

    pwr_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_en;
    logic             w_irq_rise;
    logic             w_wake;

`ifdef SERVANT_PWR_CTRL_IRQ_WAKE_EN
    localparam int SYNC_N = clamp_sync_stages(SYNC_STAGES);

    logic w_irq_sync;
    logic r_irq_d;
    logic r_irq_pending;

    servant_sync #(.STAGES(SYNC_N)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (bus.ext_irq),
        .o_q     (w_irq_sync)
    );

    // Edge flop resets to 0 like the synchronizer, so release cannot fake an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_d       <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            r_irq_d <= w_irq_sync;
            if (w_irq_rise) begin
                r_irq_pending <= 1'b1;
            end else if (bus.irq_ack) begin
                r_irq_pending <= 1'b0;
            end
        end
    end

    assign w_irq_rise      = w_irq_sync & ~r_irq_d;
    assign bus.irq_pending = r_irq_pending;
`else
    logic [33:0] w_unused_irq;
    assign w_unused_irq    = {bus.ext_irq, bus.irq_ack, 32'(SYNC_STAGES)};
    assign w_irq_rise      = 1'b0;
    assign bus.irq_pending = 1'b0;
`endif

    assign w_wake = bus.wakeup_req | w_irq_rise;

    // Counters only decrement while non-zero; reaching 0 is the phase exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_clk_en <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_clk_en <= 1'b1;
                    if (bus.sleep_req && !w_wake) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (w_wake) begin
                        r_state  <= ST_RUN;
                        r_cnt    <= '0;
                        r_clk_en <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state  <= ST_SLEEP;
                        r_clk_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SLEEP: begin
                    r_clk_en <= 1'b0;
                    if (w_wake) begin
                        r_state <= ST_WAKE;
                        r_cnt   <= WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_RUN;
                        r_clk_en <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt - 1'b1;
                        r_clk_en <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_cnt    <= '0;
                    r_clk_en <= 1'b1;
                end
            endcase
        end
    end

    assign bus.clk_en = r_clk_en;
    assign bus.state  = r_state;
endmodule

// File: rtl/servant_sync.sv
// Multi-flop synchronizer for an asynchronous level; every stage resets to 0.
// Only built when SERVANT_PWR_CTRL_IRQ_WAKE_EN is defined.
module servant_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/servant_pwr_ctrl.sv
// Top of the servant power controller: flat pins bundled onto the request interface.
// Build macro SERVANT_PWR_CTRL_IRQ_WAKE_EN enables external-interrupt wake.
module servant_pwr_ctrl
    import servant_pwr_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DRAIN_CYCLES = 16,
    parameter int WAKE_CYCLES  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sleep_req,
    input  logic       i_wakeup_req,
    input  logic       i_ext_irq,
    input  logic       i_irq_ack,
    output logic       o_clk_en,
    output logic       o_irq_pending,
    output logic [1:0] o_state
);
    servant_pwr_ctrl_if w_bus ();

    assign w_bus.sleep_req  = i_sleep_req;
    assign w_bus.wakeup_req = i_wakeup_req;
    assign w_bus.ext_irq    = i_ext_irq;
    assign w_bus.irq_ack    = i_irq_ack;

    servant_pwr_ctrl_fsm #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .WAKE_CYCLES  (WAKE_CYCLES)
    ) u_fsm (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (w_bus.slave)
    );

    assign o_clk_en      = w_bus.clk_en;
    assign o_irq_pending = w_bus.irq_pending;
    assign o_state       = w_bus.state;
endmodule

// File: tb/tb_servant_pwr_ctrl.sv
// Scoreboarded bench for servant_pwr_ctrl: directed scenarios then random traffic,
// checked every cycle against a phase/remaining-cycles reference model.
module tb_servant_pwr_ctrl;
    localparam int SYNC   = 2;
    localparam int DRAIN  = 16;
    localparam int WAKE   = 8;
    localparam int N_RAND = 3000;

    logic clk;
    logic rst_n;
    servant_pwr_ctrl_if pif ();

    servant_pwr_ctrl #(
        .SYNC_STAGES  (SYNC),
        .DRAIN_CYCLES (DRAIN),
        .WAKE_CYCLES  (WAKE)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sleep_req   (pif.sleep_req),
        .i_wakeup_req  (pif.wakeup_req),
        .i_ext_irq     (pif.ext_irq),
        .i_irq_ack     (pif.irq_ack),
        .o_clk_en      (pif.clk_en),
        .o_irq_pending (pif.irq_pending),
        .o_state       (pif.state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {state[1:0], clk_en, irq_pending}
    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // reference model: phase 0=RUN 1=DRAIN 2=SLEEP 3=WAKE, cycles left in timed phase
    int   m_phase;
    int   m_left;
    logic m_pending;
    logic irq_hist[$];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got state=%0d clk_en=%b pend=%b, expected state=%0d clk_en=%b pend=%b (t=%0t)",
                     name, got[3:2], got[1], got[0], exp[3:2], exp[1], exp[0], $time);
        end
    endtask

    function automatic logic [3:0] model_out();
        logic en;
        en = (m_phase == 0) || (m_phase == 1);
        return {2'(m_phase), en, m_pending};
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_left    = 0;
        m_pending = 1'b0;
        irq_hist.delete();
    endtask

    // Advance the model across one clock edge with the inputs present at that edge.
    task automatic model_edge(input logic s, input logic w, input logic x, input logic a);
        int   n;
        logic cur;
        logic prv;
        logic rise;
        logic wake;
        irq_hist.push_back(x);
        n   = irq_hist.size();
        // the synchronized level seen now was sampled SYNC edges ago
        cur = (n - 1 - SYNC >= 0) ? irq_hist[n-1-SYNC] : 1'b0;
        prv = (n - 2 - SYNC >= 0) ? irq_hist[n-2-SYNC] : 1'b0;
`ifdef SERVANT_PWR_CTRL_IRQ_WAKE_EN
        rise = cur & ~prv;
`else
        rise = 1'b0;
`endif
        if (n > SYNC + 2) void'(irq_hist.pop_front());
        wake = w | rise;
        case (m_phase)
            0: if (s && !wake) begin m_phase = 1; m_left = DRAIN; end
            1: begin
                if (wake) m_phase = 0;
                else begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
            end
            2: if (wake) begin m_phase = 3; m_left = WAKE; end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
        if (rise) m_pending = 1'b1;
        else if (a) m_pending = 1'b0;
`ifndef SERVANT_PWR_CTRL_IRQ_WAKE_EN
        m_pending = 1'b0;
`endif
    endtask

    // driver: called just after a rising edge, returns just after the next one
    task automatic step(input logic s, input logic w, input logic x, input logic a);
        pif.sleep_req  = s;
        pif.wakeup_req = w;
        pif.ext_irq    = x;
        pif.irq_ack    = a;
        model_edge(s, w, x, a);
        @(posedge clk);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic idle(input int n, input logic x);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, x, 1'b0);
    endtask

    task automatic drive_idle_inputs();
        pif.sleep_req  = 1'b0;
        pif.wakeup_req = 1'b0;
        pif.ext_irq    = 1'b0;
        pif.irq_ack    = 1'b0;
    endtask

    // asserts reset away from any edge and checks the outputs before a clock arrives
    task automatic async_reset(input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        drive_idle_inputs();
        #1;
        check(name, {pif.state, pif.clk_en, pif.irq_pending}, 4'b00_1_0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_release"}, {pif.state, pif.clk_en, pif.irq_pending}, 4'b00_1_0);
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && exp_q.size() != 0) begin
            check("cycle", {pif.state, pif.clk_en, pif.irq_pending}, exp_q.pop_front());
        end
    end

    // stimulus
    initial begin
        logic s, w, a;
        logic x;
        rst_n = 1'b1;
        drive_idle_inputs();
        model_reset();
        #2;
        async_reset("reset");

        // sleep pulse: 16 enabled drain cycles, then SLEEP
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(DRAIN + 3, 1'b0);
        // wake from sleep through the settle phase back to RUN
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(WAKE + 3, 1'b0);
        // simultaneous sleep and wake in RUN stays RUN
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        // wakeup mid-drain aborts back to RUN
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        // irq rising edge in SLEEP, then ack coincident with a fresh edge
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(DRAIN + 2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(WAKE + 4, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(SYNC - 1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0);
        // irq toggling while asleep
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(DRAIN + 2, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(WAKE + 2, 1'b0);
        // reset mid-settle: sleep, wake, advance to count 4
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(DRAIN + 2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        async_reset("reset_mid_wake");

        // random traffic
        x = 1'b0;
        for (int i = 0; i < N_RAND; i++) begin
            s = ($urandom_range(0, 5) == 0);
            w = ($urandom_range(0, 24) == 0);
            a = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) x = ~x;
            step(s, w, x, a);
            if ($urandom_range(0, 399) == 0) begin
                async_reset("reset_random");
                x = 1'b0;
            end
        end
        drive_idle_inputs();

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_queue: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
